// File: rtl/pintar_scan_if.sv
// Signal bundle between the pattern source / matrix pins and the row-scan controller.
// STATE_DBG encoding: 0 = IDLE, 1 = LATCH, 2 = BLANK, 3 = SHOW.
interface pintar_scan_if #(
    parameter int DATAWIDTH_DATA = 8
);
    logic                      PINTAR_SCAN_ENABLE_In;
    logic [DATAWIDTH_DATA-1:0] PINTAR_SCAN_ROW7_In;
    logic [DATAWIDTH_DATA-1:0] PINTAR_SCAN_ROW6_In;
    logic [DATAWIDTH_DATA-1:0] PINTAR_SCAN_ROW5_In;
    logic [DATAWIDTH_DATA-1:0] PINTAR_SCAN_ROW4_In;
    logic [DATAWIDTH_DATA-1:0] PINTAR_SCAN_ROW3_In;
    logic [DATAWIDTH_DATA-1:0] PINTAR_SCAN_ROW2_In;
    logic [DATAWIDTH_DATA-1:0] PINTAR_SCAN_ROW1_In;
    logic [DATAWIDTH_DATA-1:0] PINTAR_SCAN_ROW0_In;
    logic [7:0]                PINTAR_SCAN_ROWSEL_OUT;
    logic [DATAWIDTH_DATA-1:0] PINTAR_SCAN_COLUMN_OUT;
    logic [2:0]                PINTAR_SCAN_ROWIDX_OUT;
    logic                      PINTAR_SCAN_FRAME_DONE_OUT;
    logic [1:0]                PINTAR_SCAN_STATE_DBG_OUT;

    modport master (
        output PINTAR_SCAN_ENABLE_In,
        output PINTAR_SCAN_ROW7_In, PINTAR_SCAN_ROW6_In, PINTAR_SCAN_ROW5_In, PINTAR_SCAN_ROW4_In,
        output PINTAR_SCAN_ROW3_In, PINTAR_SCAN_ROW2_In, PINTAR_SCAN_ROW1_In, PINTAR_SCAN_ROW0_In,
        input  PINTAR_SCAN_ROWSEL_OUT, PINTAR_SCAN_COLUMN_OUT, PINTAR_SCAN_ROWIDX_OUT,
        input  PINTAR_SCAN_FRAME_DONE_OUT, PINTAR_SCAN_STATE_DBG_OUT
    );

    modport slave (
        input  PINTAR_SCAN_ENABLE_In,
        input  PINTAR_SCAN_ROW7_In, PINTAR_SCAN_ROW6_In, PINTAR_SCAN_ROW5_In, PINTAR_SCAN_ROW4_In,
        input  PINTAR_SCAN_ROW3_In, PINTAR_SCAN_ROW2_In, PINTAR_SCAN_ROW1_In, PINTAR_SCAN_ROW0_In,
        output PINTAR_SCAN_ROWSEL_OUT, PINTAR_SCAN_COLUMN_OUT, PINTAR_SCAN_ROWIDX_OUT,
        output PINTAR_SCAN_FRAME_DONE_OUT, PINTAR_SCAN_STATE_DBG_OUT
    );
endinterface

// File: rtl/pintar_scan_controller.sv
// Row-scan sequencer for the 8x8 LED matrix: latches a frame of row patterns, then
// walks rows 7..0 with a dark blanking gap before each lit window.
module pintar_scan_controller #(
    parameter int DATAWIDTH_DATA = 8,
    parameter int BLANK_CYCLES   = 500,
    parameter int SHOW_CYCLES    = 49500
) (
    input logic         PINTAR_SCAN_CLOCK_50,
    input logic         PINTAR_SCAN_RESET_InHigh,
    pintar_scan_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        BLANK = 2'd2,
        SHOW  = 2'd3
    } scan_state_e;

    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
    localparam logic [15:0] SHOW_LAST  = 16'(SHOW_CYCLES - 1);

    scan_state_e               state, state_n;
    logic [15:0]               cnt, cnt_n;
    logic [2:0]                idx, idx_n;
    logic                      load;
    logic                      done_n;
    logic [7:0]                rowsel_q, rowsel_n;
    logic [DATAWIDTH_DATA-1:0] column_q, column_n;
    logic                      done_q;
    logic [DATAWIDTH_DATA-1:0] frame_buf [8];
    logic [DATAWIDTH_DATA-1:0] rows_in   [8];

    always_comb begin
        rows_in[7] = bus.PINTAR_SCAN_ROW7_In;
        rows_in[6] = bus.PINTAR_SCAN_ROW6_In;
        rows_in[5] = bus.PINTAR_SCAN_ROW5_In;
        rows_in[4] = bus.PINTAR_SCAN_ROW4_In;
        rows_in[3] = bus.PINTAR_SCAN_ROW3_In;
        rows_in[2] = bus.PINTAR_SCAN_ROW2_In;
        rows_in[1] = bus.PINTAR_SCAN_ROW1_In;
        rows_in[0] = bus.PINTAR_SCAN_ROW0_In;
    end

    // Next-state logic; idx returns to 7 whenever the next state is IDLE or LATCH.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        load    = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.PINTAR_SCAN_ENABLE_In) state_n = LATCH;
            end
            LATCH: begin
                cnt_n = '0;
                idx_n = 3'd7;
                if (bus.PINTAR_SCAN_ENABLE_In) begin
                    load    = 1'b1;
                    state_n = BLANK;
                end else begin
                    state_n = IDLE;
                end
            end
            BLANK: begin
                if (!bus.PINTAR_SCAN_ENABLE_In) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = 3'd7;
                end else if (cnt == BLANK_LAST) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            SHOW: begin
                // A completed frame reports FRAME_DONE even when ENABLE drops on its last cycle.
                if (cnt == SHOW_LAST && idx == 3'd0) begin
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    idx_n   = 3'd7;
                    state_n = bus.PINTAR_SCAN_ENABLE_In ? LATCH : IDLE;
                end else if (!bus.PINTAR_SCAN_ENABLE_In) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = 3'd7;
                end else if (cnt == SHOW_LAST) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    idx_n   = idx - 3'd1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = 3'd7;
            end
        endcase

        rowsel_n = '0;
        column_n = '0;
        if (state_n == SHOW) begin
            rowsel_n = 8'd1 << idx_n;
            column_n = frame_buf[idx_n];
        end
    end

    always_ff @(posedge PINTAR_SCAN_CLOCK_50) begin
        if (PINTAR_SCAN_RESET_InHigh) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= 3'd7;
            rowsel_q <= '0;
            column_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            rowsel_q <= rowsel_n;
            column_q <= column_n;
            done_q   <= done_n;
        end
    end

    always_ff @(posedge PINTAR_SCAN_CLOCK_50) begin
        if (PINTAR_SCAN_RESET_InHigh) begin
            for (int i = 0; i < 8; i++) frame_buf[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 8; i++) frame_buf[i] <= rows_in[i];
        end
    end

    assign bus.PINTAR_SCAN_ROWSEL_OUT     = rowsel_q;
    assign bus.PINTAR_SCAN_COLUMN_OUT     = column_q;
    assign bus.PINTAR_SCAN_ROWIDX_OUT     = idx;
    assign bus.PINTAR_SCAN_FRAME_DONE_OUT = done_q;
    assign bus.PINTAR_SCAN_STATE_DBG_OUT  = state;
endmodule

// File: tb/tb_pintar_scan_controller.sv
// Bench for pintar_scan_controller with BLANK_CYCLES=2, SHOW_CYCLES=3 (frame period 41).
module tb_pintar_scan_controller;
  localparam int DW        = 8;
  localparam int B         = 2;
  localparam int S         = 3;
  localparam int ROW_LEN   = B + S;
  localparam int FRAME_LEN = 1 + 8 * ROW_LEN;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          en;
  logic [DW-1:0] rows [8];

  pintar_scan_if #(.DATAWIDTH_DATA(DW)) bus ();

  assign bus.PINTAR_SCAN_ENABLE_In = en;
  assign bus.PINTAR_SCAN_ROW7_In   = rows[7];
  assign bus.PINTAR_SCAN_ROW6_In   = rows[6];
  assign bus.PINTAR_SCAN_ROW5_In   = rows[5];
  assign bus.PINTAR_SCAN_ROW4_In   = rows[4];
  assign bus.PINTAR_SCAN_ROW3_In   = rows[3];
  assign bus.PINTAR_SCAN_ROW2_In   = rows[2];
  assign bus.PINTAR_SCAN_ROW1_In   = rows[1];
  assign bus.PINTAR_SCAN_ROW0_In   = rows[0];

  pintar_scan_controller #(
    .DATAWIDTH_DATA(DW),
    .BLANK_CYCLES(B),
    .SHOW_CYCLES(S)
  ) dut (
    .PINTAR_SCAN_CLOCK_50(clk),
    .PINTAR_SCAN_RESET_InHigh(rst),
    .bus(bus)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int done_count = 0;
  logic [DW-1:0] exp_q[$];
  logic [7:0] prev_rowsel = '0;

  // reference model: position inside the frame schedule (-1 = idle, 0 = latch cycle)
  int            m_pos = -1;
  logic [DW-1:0] m_buf [8];
  logic          m_done = 1'b0;
  logic [7:0]    exp_rowsel;
  logic [DW-1:0] exp_col;
  logic [2:0]    exp_idx;
  logic [1:0]    exp_state;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pos  = -1;
      m_done = 1'b0;
      for (int i = 0; i < 8; i++) m_buf[i] = '0;
    end else if (m_pos < 0) begin
      m_done = 1'b0;
      if (en) m_pos = 0;
    end else if (m_pos == FRAME_LEN - 1) begin
      m_done = 1'b1;
      m_pos  = en ? 0 : -1;
    end else if (!en) begin
      m_done = 1'b0;
      m_pos  = -1;
    end else begin
      m_done = 1'b0;
      if (m_pos == 0) for (int i = 0; i < 8; i++) m_buf[i] = rows[i];
      m_pos++;
    end
  endtask

  task automatic model_outputs();
    int q, r, w;
    exp_rowsel = '0;
    exp_col    = '0;
    exp_idx    = 3'd7;
    if (m_pos < 0) begin
      exp_state = 2'd0;
    end else if (m_pos == 0) begin
      exp_state = 2'd1;
    end else begin
      q = m_pos - 1;
      r = 7 - q / ROW_LEN;
      w = q % ROW_LEN;
      exp_idx = 3'(r);
      if (w >= B) begin
        exp_state  = 2'd3;
        exp_rowsel = 8'(1 << r);
        exp_col    = m_buf[r];
      end else begin
        exp_state = 2'd2;
      end
    end
  endtask

  // driver: one clock, then compare every output against the model
  task automatic step();
    @(posedge clk);
    model_edge();
    model_outputs();
    #1;
    cycle++;
    check("rowsel", bus.PINTAR_SCAN_ROWSEL_OUT, exp_rowsel);
    check("column", bus.PINTAR_SCAN_COLUMN_OUT, exp_col);
    check("rowidx", bus.PINTAR_SCAN_ROWIDX_OUT, exp_idx);
    check("frame_done", bus.PINTAR_SCAN_FRAME_DONE_OUT, m_done);
    check("state", bus.PINTAR_SCAN_STATE_DBG_OUT, exp_state);
    check("rowsel_onehot0", $onehot0(bus.PINTAR_SCAN_ROWSEL_OUT), 1'b1);
    if (bus.PINTAR_SCAN_ROWSEL_OUT == 8'h00) check("dark_column", bus.PINTAR_SCAN_COLUMN_OUT, '0);
    if (bus.PINTAR_SCAN_ROWSEL_OUT != 8'h00 && prev_rowsel == 8'h00 && exp_q.size() > 0)
      check("window_column", bus.PINTAR_SCAN_COLUMN_OUT, exp_q.pop_front());
    if (bus.PINTAR_SCAN_FRAME_DONE_OUT === 1'b1) done_count++;
    prev_rowsel = bus.PINTAR_SCAN_ROWSEL_OUT;
  endtask

  task automatic wait_rowsel(input logic [7:0] v, input string tag);
    int k = 0;
    while (bus.PINTAR_SCAN_ROWSEL_OUT !== v && k < 200) begin
      step();
      k++;
    end
    check(tag, bus.PINTAR_SCAN_ROWSEL_OUT, v);
  endtask

  task automatic wait_done(output int at);
    int k = 0;
    while (bus.PINTAR_SCAN_FRAME_DONE_OUT !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    check("done_seen", bus.PINTAR_SCAN_FRAME_DONE_OUT, 1'b1);
    at = cycle;
    step();
  endtask

  task automatic randomize_rows();
    for (int i = 0; i < 8; i++) rows[i] = DW'($urandom);
  endtask

  initial begin
    int n, a, b, k;
    logic [DW-1:0] pat [8];

    // reset held with enable high and random rows
    en = 1'b1;
    randomize_rows();
    rst = 1'b1;
    repeat (3) begin
      step();
      check("reset_rowidx", bus.PINTAR_SCAN_ROWIDX_OUT, 3'd7);
    end

    // directed pattern frame
    pat[7] = 8'hFF; pat[6] = 8'hFF; pat[5] = 8'h18; pat[4] = 8'h18;
    pat[3] = 8'h18; pat[2] = 8'h18; pat[1] = 8'hFF; pat[0] = 8'hFF;
    for (int i = 0; i < 8; i++) rows[i] = pat[i];
    for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i]);
    rst = 1'b0;
    n = 0;
    while (bus.PINTAR_SCAN_ROWSEL_OUT === 8'h00 && n < 50) begin
      step();
      n++;
    end
    check("first_lit_delay", 16'(n), 16'd4);
    check("first_rowsel", bus.PINTAR_SCAN_ROWSEL_OUT, 8'h80);
    wait_done(a);
    wait_done(b);
    check("done_period", 16'(b - a), 16'(FRAME_LEN));
    check("pattern_windows_seen", 16'(exp_q.size()), 16'd0);

    // inputs cleared during row 4: old data for rows 3..0, zeros next frame
    wait_rowsel(8'h10, "row4_show");
    for (int i = 0; i < 8; i++) rows[i] = '0;
    for (int i = 3; i >= 0; i--) exp_q.push_back(pat[i]);
    repeat (8) exp_q.push_back('0);
    wait_done(a);
    wait_done(b);
    check("no_tearing_windows", 16'(exp_q.size()), 16'd0);

    // one-cycle enable drop during row 5 show
    randomize_rows();
    wait_rowsel(8'h20, "row5_show");
    en = 1'b0;
    step();
    check("abort_state", bus.PINTAR_SCAN_STATE_DBG_OUT, 2'd0);
    check("abort_rowsel", bus.PINTAR_SCAN_ROWSEL_OUT, 8'h00);
    check("abort_done", bus.PINTAR_SCAN_FRAME_DONE_OUT, 1'b0);
    en = 1'b1;
    step();
    check("restart_latch", bus.PINTAR_SCAN_STATE_DBG_OUT, 2'd1);
    check("restart_rowidx", bus.PINTAR_SCAN_ROWIDX_OUT, 3'd7);
    wait_rowsel(8'h80, "restart_row7");

    // reset during row 2 blanking
    k = 0;
    while (!(m_pos > 0 && exp_idx == 3'd2 && exp_rowsel == 8'h00) && k < 200) begin
      step();
      k++;
    end
    check("row2_blank_found", bus.PINTAR_SCAN_ROWIDX_OUT, 3'd2);
    rst = 1'b1;
    step();
    check("midrst_rowsel", bus.PINTAR_SCAN_ROWSEL_OUT, 8'h00);
    check("midrst_column", bus.PINTAR_SCAN_COLUMN_OUT, '0);
    check("midrst_rowidx", bus.PINTAR_SCAN_ROWIDX_OUT, 3'd7);
    check("midrst_state", bus.PINTAR_SCAN_STATE_DBG_OUT, 2'd0);
    rst = 1'b0;

    // ten continuous frames with random rows
    k = 0;
    while (bus.PINTAR_SCAN_STATE_DBG_OUT !== 2'd1 && k < 50) begin
      step();
      k++;
    end
    check("latch_found", bus.PINTAR_SCAN_STATE_DBG_OUT, 2'd1);
    done_count = 0;
    repeat (10 * FRAME_LEN) begin
      randomize_rows();
      step();
    end
    check("ten_frames_done", 16'(done_count), 16'd10);

    // random enable drops and occasional resets
    repeat (1500) begin
      en  = ($urandom_range(0, 59) != 0);
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 3) == 0) randomize_rows();
      step();
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
